// File: rtl/dram_cmd_scheduler.sv
// SDRAM command sequencer shared between host read/write accesses and
// periodic auto-refresh. Owns the refresh interval timer and the count of
// postponed refreshes, arbitrates in IDLE, then runs fixed-timing sequences.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   host_req  host access request, held until host_ack
//   host_we   1 = write, 0 = read; stable while host_req is high
//   host_ack  one-cycle pulse while READ/WRITE is on the pins
//   busy      high whenever the sequencer is not IDLE
//   ref_debt  outstanding refresh count (0..MAX_POSTPONE)
//   CS/RAS/CAS/WE  registered SDRAM command pins, active low
module dram_cmd_scheduler #(
  parameter int unsigned T_REFI       = 780,
  parameter int unsigned T_RFC        = 8,
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_req,
  input  logic       host_we,
  output logic       host_ack,
  output logic       busy,
  output logic [3:0] ref_debt,
  output logic       CS,
  output logic       RAS,
  output logic       CAS,
  output logic       WE
);

  localparam int unsigned TIMER_W     = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam int unsigned MAX_WAIT_AB = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned MAX_WAIT    = (MAX_WAIT_AB > T_RFC) ? MAX_WAIT_AB : T_RFC;
  // Counter only ever reaches MAX_WAIT-2 inside a wait state.
  localparam int unsigned WAIT_W      = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned RCD_LAST    = (T_RCD > 1) ? T_RCD - 2 : 0;
  localparam int unsigned RP_LAST     = (T_RP > 1) ? T_RP - 2 : 0;
  localparam int unsigned RFC_LAST    = (T_RFC > 1) ? T_RFC - 2 : 0;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] MAX_DEBT  = 4'(MAX_POSTPONE);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_RCD_WAIT, S_RW, S_PRE, S_RP_WAIT, S_REF, S_RFC_WAIT
  } state_t;

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [TIMER_W-1:0]  timer;
  logic                tick;
  logic                ref_issue;
  logic                in_wait;
  logic [3:0]          cmd_d;
  logic                ack_d;
  logic                busy_d;

  assign tick      = (timer == TIMER_W'(T_REFI - 1));
  assign ref_issue = (state == S_IDLE) && (state_next == S_REF);
  assign in_wait   = (state == S_RCD_WAIT) || (state == S_RP_WAIT) ||
                     (state == S_RFC_WAIT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state: arbitration in IDLE, fixed sequences elsewhere
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (ref_debt == MAX_DEBT)  state_next = S_REF;
        else if (host_req)         state_next = S_ACT;
        else if (ref_debt != 4'd0) state_next = S_REF;
      end
      S_ACT:      state_next = (T_RCD > 1) ? S_RCD_WAIT : S_RW;
      S_RCD_WAIT: if (wait_cnt == WAIT_W'(RCD_LAST)) state_next = S_RW;
      S_RW:       state_next = S_PRE;
      S_PRE:      state_next = (T_RP > 1) ? S_RP_WAIT : S_IDLE;
      S_RP_WAIT:  if (wait_cnt == WAIT_W'(RP_LAST)) state_next = S_IDLE;
      S_REF:      state_next = (T_RFC > 1) ? S_RFC_WAIT : S_IDLE;
      S_RFC_WAIT: if (wait_cnt == WAIT_W'(RFC_LAST)) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode of the state being entered, so pins line up with the state
  always_comb begin
    cmd_d  = CMD_NOP;
    ack_d  = 1'b0;
    busy_d = (state_next != S_IDLE);
    case (state_next)
      S_ACT: cmd_d = CMD_ACT;
      S_RW: begin
        cmd_d = host_we ? CMD_WRITE : CMD_READ;
        ack_d = 1'b1;
      end
      S_PRE:   cmd_d = CMD_PRE;
      S_REF:   cmd_d = CMD_REF;
      default: cmd_d = CMD_NOP;
    endcase
  end

  // Registered pins and status
  always_ff @(posedge clk) begin
    if (reset) begin
      {CS, RAS, CAS, WE} <= CMD_DESEL;
      host_ack           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      {CS, RAS, CAS, WE} <= cmd_d;
      host_ack           <= ack_d;
      busy               <= busy_d;
    end
  end

  // Wait-state cycle counter, cleared on every state change
  always_ff @(posedge clk) begin
    if (reset)                    wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (in_wait)             wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Free-running refresh interval timer
  always_ff @(posedge clk) begin
    if (reset)     timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + TIMER_W'(1);
  end

  // Refresh debt: tick adds, REF issue removes, both together cancel
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_debt <= 4'd0;
    end else if (tick && !ref_issue) begin
      if (ref_debt != MAX_DEBT) ref_debt <= ref_debt + 4'd1;
    end else if (ref_issue && !tick) begin
      ref_debt <= ref_debt - 4'd1;
    end
  end

endmodule
